// File: rtl/move_executor.sv
// -----------------------------------------------------------------------------
// move_executor
//   Retires one decoded register-to-register move per transaction. It accepts a
//   move from the decoder over a valid/ready handshake, reads the source
//   register through the combinational register-file read port, and then
//   strobes the one-hot destination write enable.
//
//   Optional feature macro: MOVE_ZERO_FLAG_EN
//     When defined, adds o_zero_flag / o_zero_flag_we. These are driven during
//     the write cycle and report whether the value written is zero.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_mv_valid, o_mv_ready  move handshake; ready is high only while idle
//   i_acc_sel               move targets the accumulator path (dest must be A)
//   i_source_reg_sel        source register index
//   i_destination_reg_flag  one-hot destination (bit0=A .. bit3=D)
//   o_rf_rd_sel             register-file read select, held outside READ
//   i_rf_rd_data            register-file read data (combinational)
//   o_rf_wr_en              one-hot register write strobe
//   o_rf_wr_data            register write data
//   o_acc_wr_en             accumulator-path write strobe
//   o_zero_flag(_we)        (MOVE_ZERO_FLAG_EN only) zero flag and its strobe
//   o_done                  1-cycle pulse when a move retires (including NOP)
//   o_err                   1-cycle pulse when an illegal move is rejected
// -----------------------------------------------------------------------------
module move_executor #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned REG_COUNT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_mv_valid,
   output logic              o_mv_ready,
   input  logic              i_acc_sel,
   input  logic [2:0]        i_source_reg_sel,
   input  logic [3:0]        i_destination_reg_flag,
   output logic [2:0]        o_rf_rd_sel,
   input  logic [DATA_W-1:0] i_rf_rd_data,
   output logic [3:0]        o_rf_wr_en,
   output logic [DATA_W-1:0] o_rf_wr_data,
   output logic              o_acc_wr_en,
`ifdef MOVE_ZERO_FLAG_EN
   output logic              o_zero_flag,
   output logic              o_zero_flag_we,
`endif
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWrite,
      StNop,
      StErr
   } state_e;

   // Destination bits that name an existing register.
   localparam logic [3:0] RegMask =
      (REG_COUNT >= 4) ? 4'hF : 4'((32'd1 << REG_COUNT) - 32'd1);

   state_e              r_state;
   logic [2:0]          r_rd_sel;
   logic [3:0]          r_dest;
   logic                r_acc;
   logic [DATA_W-1:0]   r_data;
   logic [3:0]          r_wr_en;
   logic                r_acc_wr;
   logic                r_done;
   logic                r_err;
   logic                r_zf;
   logic                r_zf_we;

   logic                w_dest_ok;
   logic                w_src_ok;
   logic                w_acc_ok;
   logic                w_legal;
   logic                w_self;

   always_comb begin
      w_dest_ok = $onehot(i_destination_reg_flag)
                  && ((i_destination_reg_flag & ~RegMask) == 4'b0000);
      w_src_ok  = 32'(i_source_reg_sel) < REG_COUNT;
      w_acc_ok  = !i_acc_sel || (i_destination_reg_flag == 4'b0001);
      w_legal   = w_dest_ok && w_src_ok && w_acc_ok;
      // Source and destination name the same register: retire as a NOP.
      w_self    = ((4'b0001 << i_source_reg_sel) == i_destination_reg_flag);
   end

   // Ready is forced low while reset is asserted, even though the state is idle.
   assign o_mv_ready = (r_state == StIdle) && i_rst_n;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_rd_sel <= 3'd0;
         r_dest   <= 4'd0;
         r_acc    <= 1'b0;
         r_data   <= '0;
         r_wr_en  <= 4'd0;
         r_acc_wr <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_zf     <= 1'b0;
         r_zf_we  <= 1'b0;
      end else begin
         // Strobes are single-cycle; they are set only on the edge entering
         // WRITE / NOP / ERR.
         r_wr_en  <= 4'd0;
         r_acc_wr <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_zf     <= 1'b0;
         r_zf_we  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_mv_valid) begin
                  r_dest <= i_destination_reg_flag;
                  r_acc  <= i_acc_sel;
                  if (!w_legal) begin
                     r_state <= StErr;
                     r_err   <= 1'b1;
                  end else if (w_self) begin
                     r_state <= StNop;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= StRead;
                     r_rd_sel <= i_source_reg_sel;
                  end
               end
            end
            StRead: begin
               r_state  <= StWrite;
               r_data   <= i_rf_rd_data;
               r_wr_en  <= r_dest;
               r_acc_wr <= r_acc;
               r_done   <= 1'b1;
               r_zf_we  <= 1'b1;
               r_zf     <= (i_rf_rd_data == '0);
            end
            StWrite, StNop, StErr: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_rf_rd_sel  = r_rd_sel;
   assign o_rf_wr_en   = r_wr_en;
   assign o_rf_wr_data = r_data;
   assign o_acc_wr_en  = r_acc_wr;
   assign o_done       = r_done;
   assign o_err        = r_err;

`ifdef MOVE_ZERO_FLAG_EN
   assign o_zero_flag    = r_zf;
   assign o_zero_flag_we = r_zf_we;
`else
   // Zero-flag tracking is not exported in this build.
   logic w_zf_unused;
   assign w_zf_unused = r_zf ^ r_zf_we;
`endif

endmodule

// File: tb/tb_move_executor.sv
// -----------------------------------------------------------------------------
// tb_move_executor
//   Self-checking bench for move_executor. A small register-file array acts as
//   the read port and as the reference for the values moved. Each move's
//   expected cycle-by-cycle behaviour is derived from the legality rules and
//   the 3-cycle / 2-cycle transaction shapes.
// -----------------------------------------------------------------------------
module tb_move_executor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mv_valid = 1'b0;
   logic       mv_ready;
   logic       acc_sel = 1'b0;
   logic [2:0] src = 3'd0;
   logic [3:0] dest = 4'd0;
   logic [2:0] rd_sel;
   logic [7:0] rd_data;
   logic [3:0] wr_en;
   logic [7:0] wr_data;
   logic       acc_wr;
   logic       done;
   logic       err;
`ifdef MOVE_ZERO_FLAG_EN
   logic       zf;
   logic       zf_we;
`endif

   logic [7:0] rf [4];
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      rd_data = 8'hEE;
      if (rd_sel < 3'd4) rd_data = rf[rd_sel[1:0]];
   end

   move_executor #(.DATA_W(8), .REG_COUNT(4)) dut (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_mv_valid             (mv_valid),
      .o_mv_ready             (mv_ready),
      .i_acc_sel              (acc_sel),
      .i_source_reg_sel       (src),
      .i_destination_reg_flag (dest),
      .o_rf_rd_sel            (rd_sel),
      .i_rf_rd_data           (rd_data),
      .o_rf_wr_en             (wr_en),
      .o_rf_wr_data           (wr_data),
      .o_acc_wr_en            (acc_wr),
`ifdef MOVE_ZERO_FLAG_EN
      .o_zero_flag            (zf),
      .o_zero_flag_we         (zf_we),
`endif
      .o_done                 (done),
      .o_err                  (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // No strobes, no pulses; ready as given.
   task automatic check_quiet(input string tag, input logic exp_ready);
      check_eq({tag, "/ready"}, 32'(mv_ready), 32'(exp_ready));
      check_eq({tag, "/wr_en"}, 32'(wr_en), 0);
      check_eq({tag, "/acc_wr"}, 32'(acc_wr), 0);
      check_eq({tag, "/done"}, 32'(done), 0);
      check_eq({tag, "/err"}, 32'(err), 0);
`ifdef MOVE_ZERO_FLAG_EN
      check_eq({tag, "/zf_we"}, 32'(zf_we), 0);
      check_eq({tag, "/zf"}, 32'(zf), 0);
`endif
   endtask

   task automatic drive_garbage();
      mv_valid = 1'($urandom_range(0, 1));
      src      = 3'($urandom);
      dest     = 4'($urandom);
      acc_sel  = 1'($urandom);
   endtask

   // Called at a negedge while the executor is idle; returns at the negedge
   // where it is idle again, with the inputs left holding random values.
   task automatic run_move(input string tag, input logic a, input logic [2:0] s,
                           input logic [3:0] d);
      logic       legal;
      logic       self_mv;
      logic [7:0] data;
      legal   = ($countones(d) == 1) && (s < 3'd4) && !(a && (d != 4'b0001));
      self_mv = legal && (d == 4'(1 << s));
      data    = (s < 3'd4) ? rf[s[1:0]] : 8'h00;
      check_eq({tag, "/ready_pre"}, 32'(mv_ready), 1);
      mv_valid = 1'b1;
      acc_sel  = a;
      src      = s;
      dest     = d;
      @(negedge clk);
      drive_garbage();
      if (!legal) begin
         check_eq({tag, "/ready"}, 32'(mv_ready), 0);
         check_eq({tag, "/err"}, 32'(err), 1);
         check_eq({tag, "/done"}, 32'(done), 0);
         check_eq({tag, "/wr_en"}, 32'(wr_en), 0);
         check_eq({tag, "/acc_wr"}, 32'(acc_wr), 0);
      end else if (self_mv) begin
         check_eq({tag, "/ready"}, 32'(mv_ready), 0);
         check_eq({tag, "/done"}, 32'(done), 1);
         check_eq({tag, "/err"}, 32'(err), 0);
         check_eq({tag, "/wr_en"}, 32'(wr_en), 0);
         check_eq({tag, "/acc_wr"}, 32'(acc_wr), 0);
      end else begin
         check_quiet({tag, "/rd"}, 1'b0);
         check_eq({tag, "/rd_sel"}, 32'(rd_sel), 32'(s));
         @(negedge clk);
         drive_garbage();
         check_eq({tag, "/ready_w"}, 32'(mv_ready), 0);
         check_eq({tag, "/wr_en"}, 32'(wr_en), 32'(d));
         check_eq({tag, "/wr_data"}, 32'(wr_data), 32'(data));
         check_eq({tag, "/acc_wr"}, 32'(acc_wr), 32'(a));
         check_eq({tag, "/done"}, 32'(done), 1);
         check_eq({tag, "/err"}, 32'(err), 0);
`ifdef MOVE_ZERO_FLAG_EN
         check_eq({tag, "/zf_we"}, 32'(zf_we), 1);
         check_eq({tag, "/zf"}, 32'(zf), 32'(data == 8'h00));
`endif
         for (int i = 0; i < 4; i++) if (d[i]) rf[i] = data;
      end
      @(negedge clk);
      check_quiet({tag, "/end"}, 1'b1);
   endtask

   initial begin
      logic       a;
      logic [2:0] s;
      logic [3:0] d;
      rf[0] = 8'h5C; rf[1] = 8'h11; rf[2] = 8'h22; rf[3] = 8'h00;

      // Reset held: everything zero, not ready.
      repeat (3) @(negedge clk);
      check_quiet("rst", 1'b0);
      check_eq("rst/rd_sel", 32'(rd_sel), 0);
      check_eq("rst/wr_data", 32'(wr_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_quiet("rst_rel", 1'b1);

      // Directed moves.
      run_move("mov_b_a", 1'b0, 3'd0, 4'b0010);
      rf[3] = 8'h00;
      run_move("mov_a_d_acc", 1'b1, 3'd3, 4'b0001);
      run_move("ill_two_hot", 1'b0, 3'd1, 4'b0110);
      run_move("ill_zero", 1'b0, 3'd1, 4'b0000);
      run_move("ill_acc", 1'b1, 3'd1, 4'b0100);
      run_move("ill_src", 1'b0, 3'd5, 4'b0001);
      run_move("nop_c", 1'b0, 3'd2, 4'b0100);

      // Back-to-back legal moves.
      run_move("b2b_0", 1'b0, 3'd1, 4'b1000);
      run_move("b2b_1", 1'b0, 3'd2, 4'b0001);
      run_move("b2b_2", 1'b0, 3'd3, 4'b0100);

      // Reset during READ: the move must vanish without a write.
      rf[1] = 8'hA7;
      mv_valid = 1'b1; acc_sel = 1'b0; src = 3'd1; dest = 4'b0001;
      @(negedge clk);
      check_eq("mid_rst/rd_sel", 32'(rd_sel), 1);
      rst_n = 1'b0;
      mv_valid = 1'b0;
      #1;
      check_quiet("mid_rst/held", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_quiet("mid_rst/after", 1'b1);
      end

      // Randomised traffic with idle gaps.
      for (int it = 0; it < 300; it++) begin
         mv_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check_quiet("idle", 1'b1);
         end
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < 4; i++)
               rf[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         a = ($urandom_range(0, 3) == 0);
         s = 3'($urandom_range(0, 5));
         d = ($urandom_range(0, 2) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         if (a && ($urandom_range(0, 1) == 1)) d = 4'b0001;
         run_move("rnd", a, s, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
